sha256_padder: RTL and testbench
================================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port data_i, input, 32: message word, big-endian (byte 0 in [31:24]).
REQ-004 SHALL have port valid_i, input, 1: data_i/last_i/bytes_i valid.
REQ-005 SHALL have port last_i, input, 1: final word of message.
REQ-006 SHALL have port bytes_i, input, 2: valid bytes in final word (0 means 4); sampled only with last_i.
REQ-007 SHALL have port ready_o, output, 1: input word accepted when valid_i and ready_o are both high.
REQ-008 SHALL have port word_o, output, 32: padded block word to the message scheduler.
REQ-009 SHALL have port valid_o, output, 1: word_o valid.
REQ-010 SHALL have port ready_i, input, 1: downstream accepts word_o.
REQ-011 SHALL have port word_idx_o, output, 4: index of word_o within its 512-bit block.
REQ-012 SHALL have port block_end_o, output, 1: high with word index 15.
REQ-013 SHALL have port msg_end_o, output, 1: high with word 15 of the final block only.

Function
REQ-014 SHALL use FSM states S_DATA, S_PAD80, S_ZERO, S_LEN_HI, S_LEN_LO.
REQ-015 SHALL register outputs: an accepted input appears on word_o the next cycle.
REQ-016 SHALL drive ready_o = (state==S_DATA) && (!valid_o || ready_i).
REQ-017 SHALL hold word_o, word_idx_o, block_end_o and msg_end_o stable while valid_o && !ready_i.
REQ-018 SHALL advance word_idx_o only on an output handshake, wrapping 15->0.
REQ-019 SHALL keep a 61-bit byte counter; the length field equals the byte count << 3, as a 64-bit bit count.
REQ-020 Non-last word: SHALL pass data_i unchanged and add 4 to the byte counter.
REQ-021 Last word with k = 1..3 bytes: SHALL emit k data bytes, 0x80 in byte k and zeros after; bytes beyond k+1 SHALL be forced to 0 regardless of data_i. Then go to S_ZERO, or S_LEN_HI if the index just emitted is 13.
REQ-022 Last word with k = 4: SHALL emit data_i unchanged, then go to S_PAD80, which emits 0x80000000.
REQ-023 S_ZERO SHALL emit 0x00000000 until the next index to emit is 14, then go to S_LEN_HI.
REQ-024 If the pad word lands at index 14 or 15, SHALL zero-fill to 15, emit a second block of zeros at 0..13, then the length.
REQ-025 S_LEN_HI SHALL emit length[63:32] at index 14; S_LEN_LO SHALL emit length[31:0] at index 15 with msg_end_o high.
REQ-026 After S_LEN_LO, SHALL return to S_DATA and clear the counters.
REQ-027 Messages are at least 1 byte; no zero-length message is supported.
REQ-028 valid_i SHALL be ignored outside S_DATA.

Reset
REQ-029 On reset_i: state = S_DATA, byte counter = 0, word_idx_o = 0, valid_o = 0, word_o = 0, block_end_o = 0, msg_end_o = 0.
REQ-030 A reset mid-message SHALL discard the partial block; no word is emitted until new input is accepted.

Structure
REQ-031 Package sha256_pkg SHALL hold the state enum, SHA256_PAD_BYTE = 8'h80, SHA256_BLOCK_WORDS = 16 and SHA256_LEN_HI_IDX = 14.
REQ-032 SHALL instantiate one combinational sub-module, sha256_pad_word (data word + byte count -> masked, padded word).

Verification
REQ-033 "abc": data 0x61626300, bytes=3, last -> word0 0x61626380, words 1-14 0, word15 0x00000018, msg_end_o at index 15.
REQ-034 4 bytes 0x61626364, bytes=0 -> word0 0x61626364, word1 0x80000000, word15 0x00000020, one block.
REQ-035 55 bytes (last at index 13, bytes=3) -> word13 ends 0x80, word14 0, word15 0x000001B8, one block.
REQ-036 56 bytes (14 full words) -> word14 0x80000000, word15 0, block 2 words 0-14 0, word31 0x000001C0; block_end_o at 15 and 31, msg_end_o only at 31.
REQ-037 Random ready_i low, two back-to-back messages -> output stream identical to the no-stall case, no drop or duplicate.
REQ-038 reset_i pulsed at index 7 of a message, then "abc" -> valid_o 0 the cycle after reset, then the exact "abc" block from index 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message padder.
//   sha256_state_e  - padder FSM state encoding
//   SHA256_*        - pad byte, block geometry and length-word position
//   last_word_bytes - maps the 2-bit byte count of a final word to 1..4
package sha256_pkg;

  typedef enum logic [2:0] {
    S_DATA   = 3'd0,
    S_PAD80  = 3'd1,
    S_ZERO   = 3'd2,
    S_LEN_HI = 3'd3,
    S_LEN_LO = 3'd4
  } sha256_state_e;

  localparam logic [7:0] SHA256_PAD_BYTE    = 8'h80;
  localparam int         SHA256_BLOCK_WORDS = 16;
  localparam logic [3:0] SHA256_LEN_HI_IDX  = 4'd14;
  localparam logic [3:0] SHA256_LAST_IDX    = 4'(SHA256_BLOCK_WORDS - 1);
  // Once a pad/zero word has gone out at this index, the length words follow.
  localparam logic [3:0] SHA256_PRE_LEN_IDX = SHA256_LEN_HI_IDX - 4'd1;

  // A final word carries 1..4 bytes; the encoding 0 stands for 4.
  function automatic logic [2:0] last_word_bytes(input logic [1:0] b);
    return (b == 2'd0) ? 3'd4 : {1'b0, b};
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: combinational masking/padding of one input word.
//   data_i  [31:0] big-endian message word
//   last_i         word is the final word of the message
//   bytes_i [1:0]  valid bytes in a final word (0 means 4)
//   word_o  [31:0] data unchanged, or k data bytes + 0x80 + zeros when a
//                  final word is partial (bytes past the pad byte forced to 0)
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic        last_i,
  input  logic [1:0]  bytes_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = data_i;
    if (last_i) begin
      case (bytes_i)
        2'd1:    word_o = {data_i[31:24], SHA256_PAD_BYTE, 16'h0000};
        2'd2:    word_o = {data_i[31:16], SHA256_PAD_BYTE, 8'h00};
        2'd3:    word_o = {data_i[31:8],  SHA256_PAD_BYTE};
        default: word_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// sha256_padder: turns a stream of big-endian message words into padded
// 512-bit SHA-256 blocks, one 32-bit word per output handshake.
//   clk_i, reset_i      clock, synchronous active-high reset
//   data_i/valid_i/last_i/bytes_i, ready_o   message input
//   word_o/valid_o, ready_i                  padded word output (registered)
//   word_idx_o          index of word_o inside its block
//   block_end_o         high with word index 15
//   msg_end_o           high with word 15 of the final block
//   state_o             current FSM state (debug observation)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; while valid_o is high and ready_i low, every output is held.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [31:0]   data_i,
  input  logic          valid_i,
  input  logic          last_i,
  input  logic [1:0]    bytes_i,
  output logic          ready_o,
  output logic [31:0]   word_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [3:0]    word_idx_o,
  output logic          block_end_o,
  output logic          msg_end_o,
  output sha256_state_e state_o
);

  sha256_state_e state_q, state_d;
  logic [60:0]   byte_cnt_q, byte_cnt_d;
  logic [3:0]    cnt_q, cnt_d;      // index the next emitted word will carry
  logic [3:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic          valid_q, valid_d;
  logic          block_end_q, block_end_d;
  logic          msg_end_q, msg_end_d;

  logic [31:0]   pad_word;
  logic [63:0]   bit_len;
  logic          out_ready;
  logic          emit;

  sha256_pad_word u_pad_word (
    .data_i  (data_i),
    .last_i  (last_i),
    .bytes_i (bytes_i),
    .word_o  (pad_word)
  );

  assign bit_len   = {byte_cnt_q, 3'b000};
  assign out_ready = !valid_q || ready_i;
  assign ready_o   = (state_q == S_DATA) && out_ready;
  // In S_DATA a word is produced only for an accepted input; the padding
  // states generate their own words whenever the output register frees up.
  assign emit      = (state_q == S_DATA) ? (valid_i && ready_o) : out_ready;

  // State register plus datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_DATA;
      byte_cnt_q  <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      block_end_q <= 1'b0;
      msg_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      block_end_q <= block_end_d;
      msg_end_q   <= msg_end_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (emit) begin
      case (state_q)
        S_DATA: begin
          if (last_i) begin
            if (bytes_i == 2'd0)                state_d = S_PAD80;
            else if (cnt_q == SHA256_PRE_LEN_IDX) state_d = S_LEN_HI;
            else                                  state_d = S_ZERO;
          end
        end
        S_PAD80:  state_d = (cnt_q == SHA256_PRE_LEN_IDX) ? S_LEN_HI : S_ZERO;
        S_ZERO:   if (cnt_q == SHA256_PRE_LEN_IDX) state_d = S_LEN_HI;
        S_LEN_HI: state_d = S_LEN_LO;
        S_LEN_LO: state_d = S_DATA;
        default:  state_d = S_DATA;
      endcase
    end
  end

  // Output / datapath logic.
  always_comb begin
    word_d      = word_q;
    valid_d     = valid_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    block_end_d = block_end_q;
    msg_end_d   = msg_end_q;
    byte_cnt_d  = byte_cnt_q;
    if (emit) begin
      valid_d     = 1'b1;
      idx_d       = cnt_q;
      cnt_d       = cnt_q + 4'd1;
      block_end_d = (cnt_q == SHA256_LAST_IDX);
      msg_end_d   = (state_q == S_LEN_LO);
      case (state_q)
        S_DATA: begin
          word_d     = pad_word;
          byte_cnt_d = byte_cnt_q + (last_i ? 61'(last_word_bytes(bytes_i)) : 61'd4);
        end
        S_PAD80:  word_d = {SHA256_PAD_BYTE, 24'h000000};
        S_ZERO:   word_d = '0;
        S_LEN_HI: word_d = bit_len[63:32];
        S_LEN_LO: begin
          word_d     = bit_len[31:0];
          cnt_d      = '0;
          byte_cnt_d = '0;
        end
        default:  word_d = '0;
      endcase
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign word_o      = word_q;
  assign valid_o     = valid_q;
  assign word_idx_o  = idx_q;
  assign block_end_o = block_end_q;
  assign msg_end_o   = msg_end_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: self-checking bench for sha256_padder. A reference
// model builds the standard SHA-256 padded byte stream for each message and
// queues the expected words; a monitor pops and compares them on every
// output handshake and also checks that outputs hold while stalled.
module tb_sha256_padder;
  import sha256_pkg::*;

  logic          clk;
  logic          reset_i;
  logic [31:0]   data_i;
  logic          valid_i;
  logic          last_i;
  logic [1:0]    bytes_i;
  logic          ready_o;
  logic [31:0]   word_o;
  logic          valid_o;
  logic          ready_i;
  logic [3:0]    word_idx_o;
  logic          block_end_o;
  logic          msg_end_o;
  sha256_state_e state_o;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  bit stall_en = 1'b0;

  logic [37:0] exp_q[$];      // {msg_end, block_end, idx, word}
  logic [7:0]  msg_b[0:255];

  sha256_padder dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .last_i      (last_i),
    .bytes_i     (bytes_i),
    .ready_o     (ready_o),
    .word_o      (word_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .word_idx_o  (word_idx_o),
    .block_end_o (block_end_o),
    .msg_end_o   (msg_end_o),
    .state_o     (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream back-pressure, randomised when stall_en is set.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [37:0] cur_out, stall_word, exp_w;
  bit          stall_seen = 1'b0;
  assign cur_out = {msg_end_o, block_end_o, word_idx_o, word_o};

  always @(negedge clk) begin
    if (mon_en && !reset_i) begin
      if (stall_seen) begin
        n_cmp++;
        if (!valid_o || cur_out !== stall_word) begin
          n_err++;
          $display("FAIL hold_stable got=%h valid=%b exp=%h", cur_out, valid_o, stall_word);
        end
      end
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra got=%h exp=<none>", cur_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (cur_out !== exp_w) begin
            n_err++;
            $display("FAIL sb_word got{me,be,idx,word}=%h exp=%h", cur_out, exp_w);
          end
        end
      end
      stall_seen = valid_o && !ready_i;
      stall_word = cur_out;
    end else begin
      stall_seen = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  task automatic push_expected(input int nbytes);
    int          total;
    int          p;
    logic [63:0] bit_len;
    logic [7:0]  v;
    logic [31:0] wd;
    logic [3:0]  idx;
    total   = ((nbytes + 8) / 64 + 1) * 64;
    bit_len = 64'(nbytes) * 64'd8;
    for (int w = 0; w < total / 4; w++) begin
      wd = '0;
      for (int b = 0; b < 4; b++) begin
        p = w * 4 + b;
        if (p < nbytes)            v = msg_b[p];
        else if (p == nbytes)      v = 8'h80;
        else if (p >= total - 8)   v = bit_len[(total - 1 - p) * 8 +: 8];
        else                       v = 8'h00;
        wd = {wd[23:0], v};
      end
      idx = 4'(w % 16);
      exp_q.push_back({(w == total / 4 - 1), (idx == 4'd15), idx, wd});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic [31:0] d, input logic l, input logic [1:0] b);
    int guard;
    bit acc;
    guard   = 0;
    acc     = 1'b0;
    data_i  = d;
    last_i  = l;
    bytes_i = b;
    valid_i = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout got=ready_low exp=accept");
        acc = 1'b1;
      end
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic send_msg(input int nbytes);
    int          nw;
    int          p;
    logic [31:0] d;
    push_expected(nbytes);
    nw = (nbytes + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 4; b++) begin
        p = w * 4 + b;
        // Bytes beyond the message are junk the DUT must clear.
        d = {d[23:0], (p < nbytes) ? msg_b[p] : 8'($urandom_range(1, 255))};
      end
      drive_word(d, (w == nw - 1), 2'(nbytes % 4));
    end
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) msg_b[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 4000) begin
      @(posedge clk);
      guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d_left exp=0_left", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_msg got=%b exp=0", valid_o);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0)     begin n_err++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
    n_cmp++; if (word_o !== 32'h0)     begin n_err++; $display("FAIL rst_word got=%h exp=0", word_o); end
    n_cmp++; if (word_idx_o !== 4'h0)  begin n_err++; $display("FAIL rst_idx got=%0d exp=0", word_idx_o); end
    n_cmp++; if (block_end_o !== 1'b0) begin n_err++; $display("FAIL rst_block_end got=%b exp=0", block_end_o); end
    n_cmp++; if (msg_end_o !== 1'b0)   begin n_err++; $display("FAIL rst_msg_end got=%b exp=0", msg_end_o); end
    n_cmp++; if (ready_o !== 1'b1)     begin n_err++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
    n_cmp++; if (state_o !== S_DATA)   begin n_err++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc();
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    // Known answer for the first word, independent of the model.
    n_cmp++;
    push_expected(3);
    if (exp_q[0][31:0] !== 32'h61626380 || exp_q[15][31:0] !== 32'h00000018) begin
      n_err++;
      $display("FAIL abc_model got=%h/%h exp=61626380/00000018", exp_q[0][31:0], exp_q[15][31:0]);
    end
    exp_q.delete();
    send_msg(3);
    wait_drain();
  endtask

  task automatic test_four_bytes();
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63; msg_b[3] = 8'h64;
    send_msg(4);
    wait_drain();
  endtask

  task automatic test_boundaries();
    int lens[6] = '{55, 56, 60, 63, 64, 52};
    foreach (lens[i]) begin
      fill_random(lens[i]);
      send_msg(lens[i]);
      wait_drain();
    end
  endtask

  task automatic test_back_to_back();
    stall_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      int la;
      int lb;
      la = $urandom_range(1, 130);
      lb = $urandom_range(1, 130);
      fill_random(la);
      send_msg(la);
      fill_random(lb);
      send_msg(lb);
      wait_drain();
    end
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0;
    for (int w = 0; w < 8; w++) drive_word($urandom, 1'b0, 2'd0);
    @(negedge clk);
    n_cmp++;
    if (word_idx_o !== 4'd7 || valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_idx got=%0d/%b exp=7/1", word_idx_o, valid_o);
    end
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0 || word_idx_o !== 4'd0) begin
      n_err++;
      $display("FAIL mid_rst got=%b/%0d exp=0/0", valid_o, word_idx_o);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL mid_idle got=%b exp=0", valid_o);
      end
    end
    @(posedge clk);
    #1;
    exp_q.delete();
    mon_en = 1'b1;
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    send_msg(3);
    wait_drain();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_i = 1'b1;
    data_i  = '0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    bytes_i = 2'd0;
    @(posedge clk);
    #1;
    test_reset();
    mon_en = 1'b1;
    test_abc();
    test_four_bytes();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
